// File: rtl/tbus_arbiter_if.sv
// Signal bundle between the requesting FSMs and the tristate-bus arbiter.
// master: requester side (drives req); slave: arbiter side (drives grants/enables).
interface tbus_arbiter_if #(
  parameter int unsigned N = 4
) ();

  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [N-1:0] oe;
  logic         busy;
  logic [2:0]   owner;
  logic         tmo;

  modport master (
    output req,
    input  gnt,
    input  oe,
    input  busy,
    input  owner,
    input  tmo
  );

  modport slave (
    input  req,
    output gnt,
    output oe,
    output busy,
    output owner,
    output tmo
  );

endinterface

// File: rtl/tbus_arbiter.sv
// Round-robin arbiter for a shared tristate bus. One tri-buffer per requester;
// oe drives the buffer enables. A dead window of TURN_CYC all-off cycles is
// enforced between any two ownerships so two buffers never overlap.
// Optional forced release after MAX_HOLD grant cycles: define ARB_TIMEOUT_EN.
// The interface instance must be built with the same N as this module.
module tbus_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned TURN_CYC = 1,
  parameter int unsigned MAX_HOLD = 16
) (
  input logic           clk,
  input logic           rst,
  tbus_arbiter_if.slave bus
);

  // Elaboration-time parameter range checks.
  if (N < 2 || N > 8) begin : g_bad_n
    $error("tbus_arbiter: N must be 2..8");
  end
  if (TURN_CYC < 1 || TURN_CYC > 15) begin : g_bad_turn
    $error("tbus_arbiter: TURN_CYC must be 1..15");
  end
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
    $error("tbus_arbiter: MAX_HOLD must be 2..255");
  end

  typedef enum logic [1:0] {StIdle, StOwn, StTurn} state_e;

  state_e       state_q, state_d;
  logic [N-1:0] gnt_q, gnt_d;
  logic [2:0]   last_q, last_d;
  logic [3:0]   turn_q, turn_d;

  // Zero-padded to 8 bits so a 3-bit index is always exact.
  logic [7:0] req_pad;
  logic       found;
  logic [2:0] win;
  logic [3:0] cand;
  logic       grant_now;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;
  logic       tmo_q, tmo_d;
`endif

  assign req_pad = 8'(bus.req);

  // Round-robin pick: first set request scanning upward from last+1 with wrap.
  always_comb begin
    found = 1'b0;
    win   = last_q;
    cand  = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = {1'b0, last_q} + 4'(i);
      if (cand >= 4'(N)) begin
        cand = cand - 4'(N);
      end
      if (!found && req_pad[cand[2:0]]) begin
        found = 1'b1;
        win   = cand[2:0];
      end
    end
  end

  // Next-state logic: ownership, turnaround countdown and re-arbitration.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    turn_d    = turn_q;
    grant_now = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_d    = hold_q;
    tmo_d     = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        grant_now = found;
      end
      StOwn: begin
        if (!req_pad[last_q]) begin
          gnt_d   = '0;
          state_d = StTurn;
          turn_d  = 4'(TURN_CYC - 1);
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_q == 8'(MAX_HOLD)) begin
          // Forced release; last_q already points at this owner, so it
          // becomes lowest priority on the next arbitration.
          gnt_d   = '0;
          state_d = StTurn;
          turn_d  = 4'(TURN_CYC - 1);
          tmo_d   = 1'b1;
        end else begin
          hold_d = hold_q + 8'd1;
        end
`endif
      end
      StTurn: begin
        if (turn_q != 4'd0) begin
          turn_d = turn_q - 4'd1;
        end else if (found) begin
          grant_now = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase

    if (grant_now) begin
      state_d = StOwn;
      last_d  = win;
      for (int unsigned j = 0; j < N; j++) begin
        gnt_d[j] = (win == 3'(j));
      end
`ifdef ARB_TIMEOUT_EN
      hold_d = 8'd1;
`endif
    end
  end

  // State registers with synchronous reset; no turnaround owed after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      last_q  <= 3'(N - 1);
      turn_q  <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_q  <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      turn_q  <= turn_d;
`ifdef ARB_TIMEOUT_EN
      hold_q  <= hold_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  // Outputs: grant register drives the buffer enables directly.
  assign bus.gnt   = gnt_q;
  assign bus.oe    = gnt_q;
  assign bus.busy  = |gnt_q;
  // last_q equals the owner whenever a grant is active.
  assign bus.owner = (|gnt_q) ? last_q : 3'd0;
`ifdef ARB_TIMEOUT_EN
  assign bus.tmo   = tmo_q;
`else
  assign bus.tmo   = 1'b0;
`endif

endmodule

// File: tb/tb_tbus_arbiter.sv
// Self-checking bench for tbus_arbiter: two instances (TURN_CYC=1 and 3)
// compared every cycle against a rule-level reference model.
module tb_tbus_arbiter;

  localparam int NReq    = 4;
  localparam int TurnA   = 1;
  localparam int TurnB   = 3;
  localparam int MaxHold = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  tbus_arbiter_if #(.N(NReq)) bus0 ();
  tbus_arbiter_if #(.N(NReq)) bus1 ();

  tbus_arbiter #(.N(NReq), .TURN_CYC(TurnA), .MAX_HOLD(MaxHold)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  tbus_arbiter #(.N(NReq), .TURN_CYC(TurnB), .MAX_HOLD(MaxHold)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: current owner (-1 = none), last winner, remaining
  // off-cycles before arbitration may grant, grant-cycle count, tmo pulse.
  int m_own  [2];
  int m_last [2];
  int m_wait [2];
  int m_hold [2];
  bit m_tmo  [2];

  // Gap observer: off-cycles seen since the last non-zero grant.
  int zrun [2];
  bit seen [2];

  int          order [$];
  logic [3:0]  prev_g0 = '0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int turn_of(input int k);
    return (k == 0) ? TurnA : TurnB;
  endfunction

  task automatic model_step(input int k, input logic [3:0] r, input logic rs);
    bit found;
    int c;
    m_tmo[k] = 1'b0;
    if (rs) begin
      m_own[k]  = -1;
      m_last[k] = NReq - 1;
      m_wait[k] = 0;
      m_hold[k] = 0;
      seen[k]   = 1'b0;
      zrun[k]   = 0;
      return;
    end
    if (m_own[k] >= 0) begin
      if (!r[m_own[k]]) begin
        m_own[k]  = -1;
        m_wait[k] = turn_of(k);
      end else if (TmoEn && m_hold[k] >= MaxHold) begin
        m_own[k]  = -1;
        m_wait[k] = turn_of(k);
        m_tmo[k]  = 1'b1;
      end else begin
        m_hold[k]++;
      end
    end else if (m_wait[k] > 1) begin
      m_wait[k]--;
    end else begin
      m_wait[k] = 0;
      found = 1'b0;
      for (int j = 1; j <= NReq; j++) begin
        c = (m_last[k] + j) % NReq;
        if (!found && r[c]) begin
          found     = 1'b1;
          m_own[k]  = c;
          m_last[k] = c;
          m_hold[k] = 1;
        end
      end
    end
  endtask

  task automatic check_dut(input int k, input logic [3:0] g, input logic [3:0] o,
                           input logic b, input logic [2:0] ow, input logic t);
    logic [3:0] eg;
    logic [2:0] eo;
    eg = (m_own[k] >= 0) ? 4'(1 << m_own[k]) : 4'd0;
    eo = (m_own[k] >= 0) ? 3'(m_own[k]) : 3'd0;
    chk($sformatf("gnt%0d", k), 8'(g), 8'(eg));
    chk($sformatf("oe%0d", k), 8'(o), 8'(eg));
    chk($sformatf("busy%0d", k), 8'(b), 8'(eg != 4'd0));
    chk($sformatf("owner%0d", k), 8'(ow), 8'(eo));
    chk($sformatf("tmo%0d", k), 8'(t), 8'(m_tmo[k]));
    chk($sformatf("onehot%0d", k), 8'($countones(g) <= 1), 8'd1);
    if (g != 4'd0) begin
      if (seen[k] && zrun[k] > 0) begin
        chk($sformatf("gap%0d", k), 8'(zrun[k] >= turn_of(k)), 8'd1);
      end
      seen[k] = 1'b1;
      zrun[k] = 0;
    end else begin
      zrun[k]++;
    end
  endtask

  // One clock: drive inputs, advance model at the edge, sample #1 later.
  task automatic tick(input logic [3:0] r0, input logic [3:0] r1, input logic rs);
    bus0.req = r0;
    bus1.req = r1;
    rst      = rs;
    @(posedge clk);
    model_step(0, r0, rs);
    model_step(1, r1, rs);
    #1;
    check_dut(0, bus0.gnt, bus0.oe, bus0.busy, bus0.owner, bus0.tmo);
    check_dut(1, bus1.gnt, bus1.oe, bus1.busy, bus1.owner, bus1.tmo);
    if (bus0.gnt != 4'd0 && prev_g0 == 4'd0) begin
      order.push_back(int'(bus0.owner));
    end
    prev_g0 = bus0.gnt;
  endtask

  initial begin
    logic [3:0] r;
    logic [3:0] ra;
    logic [3:0] rb;
    int         exp_order [5];

    bus0.req = '0;
    bus1.req = '0;
    exp_order = '{0, 1, 2, 3, 0};

    // Reset, then quiet bus.
    tick(4'h0, 4'h0, 1'b1);
    tick(4'h0, 4'h0, 1'b1);
    repeat (10) tick(4'h0, 4'h0, 1'b0);

    // req=0101: requester 0 first, then 2 after one turnaround cycle.
    tick(4'h0, 4'h0, 1'b1);
    tick(4'b0101, 4'b0101, 1'b0);
    chk("tp_first_gnt", 8'(bus0.gnt), 8'h01);
    repeat (4) tick(4'b0101, 4'b0101, 1'b0);
    tick(4'b0100, 4'b0100, 1'b0);
    chk("tp_turn_gnt", 8'(bus0.gnt), 8'h00);
    tick(4'b0100, 4'b0100, 1'b0);
    chk("tp_second_gnt", 8'(bus0.gnt), 8'h04);
    chk("tp_second_owner", 8'(bus0.owner), 8'd2);

    // All requesting; each owner drops for one cycle after 3 granted cycles.
    tick(4'hf, 4'hf, 1'b1);
    order.delete();
    repeat (24) begin
      r = 4'hf;
      if (m_own[0] >= 0 && m_hold[0] == 3) r[m_own[0]] = 1'b0;
      tick(r, r, 1'b0);
    end
    chk("rr_count", 8'(order.size() >= 5), 8'd1);
    for (int i = 0; i < 5; i++) begin
      if (i < order.size()) chk($sformatf("rr_order%0d", i), 8'(order[i]), 8'(exp_order[i]));
    end

    // Requester 1 toggling high 2 / low 1.
    tick(4'h0, 4'h0, 1'b1);
    repeat (8) begin
      tick(4'b0010, 4'b0010, 1'b0);
      tick(4'b0010, 4'b0010, 1'b0);
      tick(4'b0000, 4'b0000, 1'b0);
    end

    // Reset in the middle of an ownership.
    tick(4'h0, 4'h0, 1'b1);
    tick(4'b0010, 4'b0010, 1'b0);
    tick(4'b0010, 4'b0010, 1'b0);
    chk("mid_rst_pre", 8'(bus0.gnt), 8'h02);
    tick(4'hf, 4'hf, 1'b1);
    chk("mid_rst_drop", 8'(bus0.gnt), 8'h00);
    tick(4'hf, 4'hf, 1'b0);
    chk("mid_rst_regrant", 8'(bus0.gnt), 8'h01);

    // Two requesters held: forced release alternation when enabled.
    tick(4'h0, 4'h0, 1'b1);
    repeat (24) tick(4'b0011, 4'b0011, 1'b0);

    // Single requester held long: tests lone-requester re-grant / no timeout.
    tick(4'h0, 4'h0, 1'b1);
    repeat (14) tick(4'b1000, 4'b1000, 1'b0);

    // Random level requests with occasional resets.
    ra = '0;
    rb = '0;
    tick(4'h0, 4'h0, 1'b1);
    repeat (400) begin
      for (int b = 0; b < 4; b++) begin
        if (ra[b]) begin
          if ($urandom_range(5) == 0) ra[b] = 1'b0;
        end else if ($urandom_range(3) == 0) begin
          ra[b] = 1'b1;
        end
        if (rb[b]) begin
          if ($urandom_range(5) == 0) rb[b] = 1'b0;
        end else if ($urandom_range(3) == 0) begin
          rb[b] = 1'b1;
        end
      end
      tick(ra, rb, ($urandom_range(199) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
